burst_mem_ctrl: RTL and testbench

//  Word-addressed synchronous memory with burst reads/writes; serves as instruction or data memory for mips.

---
 rtl/burst_mem_ctrl.sv | 78 +++++++
 tb/tb_burst_mem_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/burst_mem_ctrl.sv
// burst_mem_ctrl: word-addressed memory with 1/4/8/16-beat burst reads/writes.
// Define MEM_OOR_ERR_EN to flag and suppress out-of-range beats instead of aliasing them.
module burst_mem_ctrl #(
  parameter logic [31:0] MEM_START = 32'h8002_0000,
  parameter int          MEM_DEPTH = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [1:0]  access_size,
  input  logic        rd_wr,
  input  logic        enable,
  output logic        busy,
  output logic        err
);
  localparam int WORDS = MEM_DEPTH / 4;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  logic [31:0] mem [WORDS];
  logic        busy_q, busy_d, rd_q, rd_d, err_q, err_d;
  logic [3:0]  beat_q, beat_d, last_q, last_d, last_n;
  logic [31:0] base_q, base_d, dout_q, dout_d;
  logic [31:0] cur, off;
  logic        act, rd, we;
  logic [IW-1:0] idx;
`ifdef MEM_OOR_ERR_EN
  logic        oor;
`endif
  always_comb begin
    act = busy_q | enable;
    rd = busy_q ? rd_q : rd_wr;
    cur = (busy_q ? base_q + {26'd0, beat_q, 2'b00} : addr) & 32'hFFFF_FFFC;
    off = cur - MEM_START;
    idx = IW'((off >> 2) % 32'(WORDS));
    last_n = access_size == 2'd0 ? 4'd0 : 4'(4'd2 << access_size) - 4'd1;
`ifdef MEM_OOR_ERR_EN
    oor = off >= 32'(MEM_DEPTH);
    we = act & ~rd & ~oor;
    err_d = act & oor;
    dout_d = act & rd ? (oor ? 32'h0 : mem[idx]) : dout_q;
`else
    we = act & ~rd;
    err_d = 1'b0;
    dout_d = act & rd ? mem[idx] : dout_q;
`endif
    // burst parameters are frozen at edge 0; later beats replay them
    base_d = busy_q ? base_q : addr;
    rd_d = busy_q ? rd_q : rd_wr;
    last_d = busy_q ? last_q : last_n;
    beat_d = busy_q ? beat_q + 4'd1 : 4'd1;
    busy_d = busy_q ? beat_q != last_q : enable && last_n != 4'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      beat_q <= 4'd0;
      last_q <= 4'd0;
      base_q <= 32'h0;
      dout_q <= 32'h0;
    end else begin
      busy_q <= busy_d;
      rd_q <= rd_d;
      err_q <= err_d;
      beat_q <= beat_d;
      last_q <= last_d;
      base_q <= base_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge clk)
    if (we && !reset) mem[idx] <= data_in;
  assign data_out = dout_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule

// File: tb/tb_burst_mem_ctrl.sv
// tb_burst_mem_ctrl: directed bursts against a beat-queue model of the memory, checked every cycle.
module tb_burst_mem_ctrl;
  localparam logic [31:0] START = 32'h8002_0000;
  localparam int DEPTH = 64;
  localparam int WORDS = DEPTH / 4;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] addr = 32'h0, data_in = 32'h0, data_out;
  logic [1:0]  access_size = 2'd0;
  logic        rd_wr = 1'b0, enable = 1'b0, busy, err;
  int n_chk = 0, n_fail = 0;
  burst_mem_ctrl #(.MEM_START(START), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out),
    .access_size(access_size), .rd_wr(rd_wr), .enable(enable), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct packed { logic [31:0] a; logic rd; } beat_t;
  beat_t       sched [$];
  logic [31:0] mem_m [WORDS];
  logic [31:0] m_dout = 32'h0;
  logic        m_busy = 1'b0, m_err = 1'b0;
  function automatic int nbeats(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 4 : s == 2'd2 ? 8 : 16;
  endfunction
  // Model: an accepted request queues all its beats; one beat retires per edge.
  always @(posedge clk or posedge reset) begin : model
    beat_t b;
    bit inr;
    int w;
    if (reset) begin
      sched.delete();
      m_busy = 1'b0;
      m_dout = 32'h0;
      m_err = 1'b0;
    end else begin
      if (sched.size() == 0 && enable)
        for (int k = 0; k < nbeats(access_size); k++)
          sched.push_back('{{addr[31:2], 2'b00} + 32'(4 * k), rd_wr});
      m_err = 1'b0;
      if (sched.size() > 0) begin
        b = sched.pop_front();
        inr = b.a >= START && b.a < START + 32'(DEPTH);
        w = int'(((b.a - START) >> 2) % WORDS);
`ifdef MEM_OOR_ERR_EN
        if (!inr) begin
          m_err = 1'b1;
          if (b.rd) m_dout = 32'h0;
        end else if (b.rd) m_dout = mem_m[w];
        else mem_m[w] = data_in;
`else
        if (b.rd) m_dout = mem_m[w];
        else mem_m[w] = data_in;
`endif
      end
      m_busy = sched.size() > 0;
    end
  end
  always @(negedge clk)
    if (!reset) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("data_out", data_out, m_dout);
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  logic [31:0] got [16];
  logic        errs [16];
  int          busy_cnt;
  // Drives one burst; got[k]/errs[k] are sampled in the cycle after beat k. hold keeps enable high through edge N.
  task automatic run(input logic [31:0] a, input logic [1:0] sz, input logic rd, input logic [31:0] d0, input bit hold);
    int n = nbeats(sz);
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) begin
        got[k-1] = data_out;
        errs[k-1] = err;
        busy_cnt += int'(busy);
      end
      enable = (k == 0) || hold;
      addr = a;
      access_size = sz;
      rd_wr = rd;
      data_in = d0 + 32'(k);
    end
    @(negedge clk);
    got[n-1] = data_out;
    errs[n-1] = err;
    busy_cnt += int'(busy);
    enable = hold;
  endtask
  task automatic drain();
    enable = 1'b0;
    repeat (18) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_dout", data_out, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    run(START, 2'd3, 1'b0, 32'h100, 1'b0);
    run(START, 2'd0, 1'b0, 32'hDEADBEEF, 1'b0);
    chk("t1_wr_busy", 32'(busy_cnt), 32'd0);
    run(START, 2'd0, 1'b1, 32'h0, 1'b0);
    chk("t1_rd", got[0], 32'hDEADBEEF);
    chk("t1_rd_busy", 32'(busy_cnt), 32'd0);
    run(START + 32'h10, 2'd1, 1'b0, 32'd1, 1'b0);
    run(START + 32'h10, 2'd1, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) chk("t2_rd", got[k], 32'(k + 1));
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd3);
    @(negedge clk);
    chk("t2_restart_busy", {31'd0, busy}, 32'd1);
    chk("t2_restart_dout", data_out, 32'd1);
    drain();
    run(START, 2'd3, 1'b1, 32'h0, 1'b1);
    chk("t3_w0", got[0], 32'hDEADBEEF);
    chk("t3_w1", got[1], 32'h101);
    chk("t3_w7", got[7], 32'd4);
    chk("t3_w15", got[15], 32'h10F);
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd15);
    @(negedge clk);
    chk("t3_restart_busy", {31'd0, busy}, 32'd1);
    chk("t3_restart_dout", data_out, 32'hDEADBEEF);
    drain();
    @(negedge clk);
    enable = 1'b1; addr = START + 32'h20; access_size = 2'd2; rd_wr = 1'b0; data_in = 32'hA0;
    @(negedge clk);
    enable = 1'b0; data_in = 32'hA1;
    @(negedge clk);
    data_in = 32'hA2;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t4_busy_now", {31'd0, busy}, 32'd0);
    chk("t4_dout_now", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(START + 32'h20, 2'd2, 1'b1, 32'h0, 1'b0);
    chk("t4_w8", got[0], 32'hA0);
    chk("t4_w10", got[2], 32'hA2);
    chk("t4_w11", got[3], 32'h10B);
    chk("t4_w15", got[7], 32'h10F);
    run(START + 32'h38, 2'd1, 1'b1, 32'h0, 1'b0);
    chk("t5_b0", got[0], 32'h10E);
    chk("t5_b1", got[1], 32'h10F);
    chk("t5_e1", {31'd0, errs[1]}, 32'd0);
`ifdef MEM_OOR_ERR_EN
    chk("t5_b2", got[2], 32'h0);
    chk("t5_b3", got[3], 32'h0);
    chk("t5_e2", {31'd0, errs[2]}, 32'd1);
    chk("t5_e3", {31'd0, errs[3]}, 32'd1);
`else
    chk("t6_b2", got[2], 32'hDEADBEEF);
    chk("t6_b3", got[3], 32'h101);
    chk("t6_e2", {31'd0, errs[2]}, 32'd0);
    chk("t6_e3", {31'd0, errs[3]}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
